// File: rtl/tval_segmenter_if.sv
// Bus between the T-value segmenter and its neighbours (sample source upstream,
// formant phi stage downstream).
//   frame_start/segment_ends : frame request and per-segment inclusive end indices
//   sample_in/sample_valid   : signed sample stream, one sample per cycle at most
//   frame_ready              : segmenter idle, a frame request will be taken
//   T_vals                   : lag-product running sums, one word per lag
//   output_start             : pulse opening a frame toward phi
//   output_valid             : pulse per T beat
//   frame_done/frame_err     : frame close pulse, error when beats were missing
// Modports: master drives the requests/samples, slave is the segmenter.
interface tval_segmenter_if #(
   parameter int BIT_WIDTH    = 32,
   parameter int SAMPLE_WIDTH = 16,
   parameter int I            = 160,
   parameter int FORMANTS     = 5,
   parameter int NU_VALUES    = 3
);
   localparam int IDX_W = $clog2(I);

   logic                                   frame_start;
   logic [FORMANTS-1:0][IDX_W-1:0]         segment_ends;
   logic signed [SAMPLE_WIDTH-1:0]         sample_in;
   logic                                   sample_valid;
   logic                                   frame_ready;
   logic [NU_VALUES-1:0][BIT_WIDTH-1:0]    T_vals;
   logic                                   output_start;
   logic                                   output_valid;
   logic                                   frame_done;
   logic                                   frame_err;

   modport master (
      output frame_start, segment_ends, sample_in, sample_valid,
      input  frame_ready, T_vals, output_start, output_valid, frame_done, frame_err
   );

   modport slave (
      input  frame_start, segment_ends, sample_in, sample_valid,
      output frame_ready, T_vals, output_start, output_valid, frame_done, frame_err
   );
endinterface

// File: rtl/tval_segmenter.sv
// Segments one analysis frame into FORMANTS pieces and emits, at the end of each
// piece, the cumulative lagged-product sums sum(x[n]*x[n-nu]) for nu = 0..NU_VALUES-1.
// Ports:
//   clk_in : system clock
//   rst_in : asynchronous active-high reset, aborts any frame in progress
//   bus    : tval_segmenter_if slave modport (requests, samples, T beats, status)
// Datapath: accept -> _p1 (full-width products) -> _p2 (accumulate, T beat).
module tval_segmenter #(
   parameter int BIT_WIDTH    = 32,
   parameter int SAMPLE_WIDTH = 16,
   parameter int I            = 160,
   parameter int FORMANTS     = 5,
   parameter int NU_VALUES    = 3
) (
   input  logic              clk_in,
   input  logic              rst_in,
   tval_segmenter_if.slave   bus
);
   localparam int IDX_W = $clog2(I);
   localparam int K_W   = $clog2(FORMANTS + 1);
   localparam int PW    = 2 * SAMPLE_WIDTH;
   localparam int H     = NU_VALUES - 1;   // history depth, NU_VALUES >= 2
   localparam logic [IDX_W-1:0] N_LAST = IDX_W'(I - 1);
   localparam logic [K_W-1:0]   K_MAX  = K_W'(FORMANTS);

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

   state_t                            state, state_nx;
   logic [FORMANTS-1:0][IDX_W-1:0]    ends_q;
   logic [IDX_W-1:0]                  n_q, cur_end;
   logic [K_W-1:0]                    k_q;
   logic                              drain_q, start_q;
   logic                              accept, start_acc, last_smp, hit;
   logic                              ready_c, done_c, err_c;
   logic signed [SAMPLE_WIDTH-1:0]    hist_q [H];
   logic signed [PW-1:0]              prod_p1 [NU_VALUES];
   logic                              vld_p1, beat_p1, vld_p2;
   logic signed [BIT_WIDTH-1:0]       acc_q  [NU_VALUES];
   logic signed [BIT_WIDTH-1:0]       acc_nx [NU_VALUES];
   logic [NU_VALUES-1:0][BIT_WIDTH-1:0] tvals_p2;

   // Full-precision signed product of two samples.
   function automatic logic signed [PW-1:0] mul(input logic signed [SAMPLE_WIDTH-1:0] a,
                                                input logic signed [SAMPLE_WIDTH-1:0] b);
      return $signed({{SAMPLE_WIDTH{a[SAMPLE_WIDTH-1]}}, a}) *
             $signed({{SAMPLE_WIDTH{b[SAMPLE_WIDTH-1]}}, b});
   endfunction

   // Product to accumulator width: sign-extend or drop high bits, sums wrap.
   function automatic logic signed [BIT_WIDTH-1:0] to_acc(input logic signed [PW-1:0] p);
      return BIT_WIDTH'(p);
   endfunction

   assign start_acc = (state == IDLE) && bus.frame_start;
   assign accept    = (state == ACCUM) && bus.sample_valid;
   assign last_smp  = accept && (n_q == N_LAST);

   // Only the boundary of the current beat is ever compared, so a repeated or
   // already-passed end index can never fire.
   always_comb begin
      cur_end = '0;
      for (int f = 0; f < FORMANTS; f++)
         if (K_W'(f) == k_q) cur_end = ends_q[f];
   end
   assign hit = accept && (k_q != K_MAX) && (n_q == cur_end);

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      ready_c  = 1'b0;
      done_c   = 1'b0;
      err_c    = 1'b0;
      case (state)
         IDLE: begin
            ready_c = 1'b1;
            if (bus.frame_start) state_nx = ACCUM;
         end
         ACCUM: if (last_smp) state_nx = DRAIN;
         DRAIN: begin
            // Second drain cycle: the last sample's stage 2 retires this cycle.
            if (drain_q) begin
               done_c   = 1'b1;
               err_c    = (k_q != K_MAX);
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         ends_q  <= '0;
         n_q     <= '0;
         k_q     <= '0;
         drain_q <= 1'b0;
         start_q <= 1'b0;
         vld_p1  <= 1'b0;
         beat_p1 <= 1'b0;
         vld_p2  <= 1'b0;
      end else begin
         start_q <= start_acc;
         drain_q <= (state == DRAIN);
         if (start_acc) begin
            ends_q <= bus.segment_ends;
            n_q    <= '0;
            k_q    <= '0;
         end else if (accept) begin
            n_q <= n_q + 1'b1;
            if (hit) k_q <= k_q + 1'b1;
         end
         vld_p1 <= accept;
         beat_p1 <= hit;
         vld_p2 <= vld_p1 && beat_p1;
      end
   end

   always_comb begin
      for (int nu = 0; nu < NU_VALUES; nu++)
         acc_nx[nu] = acc_q[nu] + to_acc(prod_p1[nu]);
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int j = 0; j < H; j++) hist_q[j] <= '0;
         for (int nu = 0; nu < NU_VALUES; nu++) begin
            prod_p1[nu] <= '0;
            acc_q[nu]   <= '0;
         end
         tvals_p2 <= '0;
      end else begin
         // Stage _p1: lag history shift and full-width products.
         if (start_acc) begin
            for (int j = 0; j < H; j++) hist_q[j] <= '0;
         end else if (accept) begin
            hist_q[0] <= bus.sample_in;
            for (int j = 1; j < H; j++) hist_q[j] <= hist_q[j-1];
         end
         if (accept) begin
            prod_p1[0] <= mul(bus.sample_in, bus.sample_in);
            for (int nu = 1; nu < NU_VALUES; nu++)
               prod_p1[nu] <= mul(bus.sample_in, hist_q[nu-1]);
         end
         // Stage _p2: accumulate, publish T values on a boundary.
         if (start_acc) begin
            for (int nu = 0; nu < NU_VALUES; nu++) acc_q[nu] <= '0;
         end else if (vld_p1) begin
            for (int nu = 0; nu < NU_VALUES; nu++) acc_q[nu] <= acc_nx[nu];
            if (beat_p1)
               for (int nu = 0; nu < NU_VALUES; nu++) tvals_p2[nu] <= acc_nx[nu];
         end
      end
   end

   assign bus.frame_ready  = ready_c;
   assign bus.frame_done   = done_c;
   assign bus.frame_err    = err_c;
   assign bus.output_start = start_q;
   assign bus.output_valid = vld_p2;
   assign bus.T_vals       = tvals_p2;
endmodule

// File: tb/tb_tval_segmenter.sv
// Directed bench for tval_segmenter: reset state, constant and alternating
// frames, ignored restart, mid-frame reset, skipped boundary, back-to-back
// beats and accumulator wrap-around.
module tb_tval_segmenter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   tval_segmenter_if bus();

   tval_segmenter dut (
      .clk_in (clk),
      .rst_in (rst),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   // per-frame observations
   logic [31:0] bt [8][3];
   int beat_cyc [8];
   int nb, cyc, start_cnt, start_first, overlap, done_cnt, err_seen, ready_after, xseen;

   function automatic logic signed [15:0] smp(input int pat, input int i);
      if (pat == 1) return (i % 2 == 0) ? 16'sd1 : -16'sd1;
      if (pat == 2) return 16'sd32767;
      return 16'sd1;
   endfunction

   task automatic obs();
      cyc++;
      if (bus.output_valid) begin
         if (nb < 8) begin
            for (int j = 0; j < 3; j++) bt[nb][j] = bus.T_vals[j];
            beat_cyc[nb] = cyc;
         end
         nb++;
      end
      if (bus.output_start) start_cnt++;
      if (bus.output_start && bus.output_valid) overlap++;
      if (bus.frame_done) begin
         done_cnt++;
         err_seen = int'(bus.frame_err);
      end
      if ($isunknown(bus.T_vals)) xseen = 1;
   endtask

   task automatic run_frame(input int pat, input logic [4:0][7:0] ends, input int restart_at);
      nb = 0; cyc = 0; start_cnt = 0; overlap = 0; done_cnt = 0; err_seen = 0; xseen = 0;
      bus.segment_ends = ends;
      bus.frame_start  = 1'b1;
      @(posedge clk); #1;
      bus.frame_start = 1'b0;
      obs();
      start_first = int'(bus.output_start);
      for (int i = 0; i < 160; i++) begin
         bus.sample_in    = smp(pat, i);
         bus.sample_valid = 1'b1;
         bus.frame_start  = (i == restart_at);
         @(posedge clk); #1;
         obs();
      end
      bus.sample_valid = 1'b0;
      bus.frame_start  = 1'b0;
      for (int w = 0; w < 20 && done_cnt == 0; w++) begin
         @(posedge clk); #1;
         obs();
      end
      @(posedge clk); #1;
      ready_after = int'(bus.frame_ready);
   endtask

   function automatic logic [4:0][7:0] std_ends();
      logic [4:0][7:0] e;
      for (int f = 0; f < 5; f++) e[f] = 8'(32 * (f + 1) - 1);
      return e;
   endfunction

   // beats for all-ones frame with standard ends, plus frame status
   task automatic check_ones(input string tag);
      int exp;
      tests++;
      if (nb !== 5) begin fails++; $display("FAIL %s beats got %0d exp 5", tag, nb); end
      for (int k = 0; k < 5 && k < nb; k++)
         for (int j = 0; j < 3; j++) begin
            exp = 32 * (k + 1) - j;
            tests++;
            if (bt[k][j] !== 32'(exp)) begin
               fails++; $display("FAIL %s T%0d beat%0d got %0d exp %0d", tag, j, k, bt[k][j], exp);
            end
         end
      tests++;
      if (start_first !== 1 || start_cnt !== 1 || overlap !== 0) begin
         fails++; $display("FAIL %s start first=%0d cnt=%0d overlap=%0d exp 1 1 0", tag, start_first, start_cnt, overlap);
      end
      tests++;
      if (done_cnt !== 1 || err_seen !== 0 || ready_after !== 1) begin
         fails++; $display("FAIL %s done=%0d err=%0d ready=%0d exp 1 0 1", tag, done_cnt, err_seen, ready_after);
      end
   endtask

   task automatic test_reset();
      bus.frame_start = 1'b0; bus.sample_valid = 1'b0; bus.sample_in = '0; bus.segment_ends = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if (bus.frame_ready !== 1'b1 || bus.output_start !== 1'b0 || bus.output_valid !== 1'b0 ||
          bus.frame_done !== 1'b0 || bus.frame_err !== 1'b0 || bus.T_vals !== '0) begin
         fails++; $display("FAIL reset outputs got rdy=%b st=%b vld=%b dn=%b er=%b T=%h exp 1 0 0 0 0 0",
            bus.frame_ready, bus.output_start, bus.output_valid, bus.frame_done, bus.frame_err, bus.T_vals);
      end
      rst = 1'b0;
      // samples in IDLE must be ignored
      bus.sample_valid = 1'b1; bus.sample_in = 16'sd100;
      repeat (3) @(posedge clk);
      #1;
      bus.sample_valid = 1'b0;
      tests++;
      if (bus.output_valid !== 1'b0 || bus.T_vals !== '0 || bus.frame_ready !== 1'b1) begin
         fails++; $display("FAIL idle_samples got vld=%b T=%h rdy=%b exp 0 0 1", bus.output_valid, bus.T_vals, bus.frame_ready);
      end
   endtask

   task automatic test_ones();
      run_frame(0, std_ends(), -1);
      check_ones("ones");
      // T values hold after the frame closes
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if (bus.T_vals[0] !== 32'd160 || bus.T_vals[1] !== 32'd159 || bus.T_vals[2] !== 32'd158) begin
         fails++; $display("FAIL hold got %0d %0d %0d exp 160 159 158", bus.T_vals[0], bus.T_vals[1], bus.T_vals[2]);
      end
   endtask

   task automatic test_alternating();
      int e0, e1, e2;
      run_frame(1, std_ends(), -1);
      tests++;
      if (nb !== 5) begin fails++; $display("FAIL alt beats got %0d exp 5", nb); end
      for (int k = 0; k < 5 && k < nb; k++) begin
         e0 = 32 * (k + 1); e1 = -(32 * (k + 1) - 1); e2 = 32 * (k + 1) - 2;
         tests++;
         if (bt[k][0] !== 32'(e0) || bt[k][1] !== 32'(e1) || bt[k][2] !== 32'(e2)) begin
            fails++; $display("FAIL alt beat%0d got %0d %0d %0d exp %0d %0d %0d", k,
               $signed(bt[k][0]), $signed(bt[k][1]), $signed(bt[k][2]), e0, e1, e2);
         end
      end
   endtask

   task automatic test_restart_ignored();
      run_frame(0, std_ends(), 50);
      check_ones("restart");
   endtask

   task automatic test_mid_reset();
      bus.segment_ends = std_ends();
      bus.frame_start  = 1'b1;
      @(posedge clk); #1;
      bus.frame_start = 1'b0;
      for (int i = 0; i < 70; i++) begin
         bus.sample_in = 16'sd1; bus.sample_valid = 1'b1;
         @(posedge clk); #1;
      end
      bus.sample_valid = 1'b0;
      tests++;
      if (bus.T_vals[0] !== 32'd64) begin
         fails++; $display("FAIL pre_reset T0 got %0d exp 64", bus.T_vals[0]);
      end
      #2 rst = 1'b1;
      #1;
      tests++;
      if (bus.T_vals !== '0 || bus.frame_ready !== 1'b1 || bus.output_valid !== 1'b0 || bus.frame_done !== 1'b0) begin
         fails++; $display("FAIL mid_reset got T=%h rdy=%b vld=%b dn=%b exp 0 1 0 0",
            bus.T_vals, bus.frame_ready, bus.output_valid, bus.frame_done);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      run_frame(0, std_ends(), -1);
      check_ones("after_reset");
   endtask

   task automatic test_skipped_boundary();
      logic [4:0][7:0] e;
      e = std_ends();
      e[2] = 8'd63;
      run_frame(0, e, -1);
      tests++;
      if (nb !== 2) begin fails++; $display("FAIL skip beats got %0d exp 2", nb); end
      tests++;
      if (bt[1][0] !== 32'd64 || bt[1][1] !== 32'd63 || bt[1][2] !== 32'd62) begin
         fails++; $display("FAIL skip beat1 got %0d %0d %0d exp 64 63 62", bt[1][0], bt[1][1], bt[1][2]);
      end
      tests++;
      if (done_cnt !== 1 || err_seen !== 1) begin
         fails++; $display("FAIL skip done/err got %0d %0d exp 1 1", done_cnt, err_seen);
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0][7:0] e;
      int e2;
      for (int f = 0; f < 5; f++) e[f] = 8'(f);
      run_frame(0, e, -1);
      tests++;
      if (nb !== 5) begin fails++; $display("FAIL b2b beats got %0d exp 5", nb); end
      tests++;
      if (beat_cyc[0] !== 3) begin fails++; $display("FAIL b2b first_beat cycle got %0d exp 3", beat_cyc[0]); end
      for (int k = 0; k < 5 && k < nb; k++) begin
         e2 = (k > 0) ? k - 1 : 0;
         tests++;
         if (bt[k][0] !== 32'(k + 1) || bt[k][1] !== 32'(k) || bt[k][2] !== 32'(e2) || beat_cyc[k] !== 3 + k) begin
            fails++; $display("FAIL b2b beat%0d got %0d %0d %0d @%0d exp %0d %0d %0d @%0d", k,
               bt[k][0], bt[k][1], bt[k][2], beat_cyc[k], k + 1, k, e2, 3 + k);
         end
      end
      tests++;
      if (done_cnt !== 1 || err_seen !== 0) begin
         fails++; $display("FAIL b2b done/err got %0d %0d exp 1 0", done_cnt, err_seen);
      end
   endtask

   task automatic test_wrap();
      longint sq;
      logic [31:0] e0, e1, e2;
      sq = 64'd32767 * 64'd32767;
      e0 = 32'(160 * sq); e1 = 32'(159 * sq); e2 = 32'(158 * sq);
      run_frame(2, std_ends(), -1);
      tests++;
      if (nb !== 5) begin fails++; $display("FAIL wrap beats got %0d exp 5", nb); end
      tests++;
      if (bt[4][0] !== 32'hFF6000A0 || bt[4][0] !== e0 || bt[4][1] !== e1 || bt[4][2] !== e2) begin
         fails++; $display("FAIL wrap last got %h %h %h exp %h %h %h", bt[4][0], bt[4][1], bt[4][2], e0, e1, e2);
      end
      tests++;
      if (bt[0][0] !== 32'(32 * sq)) begin
         fails++; $display("FAIL wrap beat0 got %h exp %h", bt[0][0], 32'(32 * sq));
      end
      tests++;
      if (xseen !== 0) begin fails++; $display("FAIL wrap xstate got %0d exp 0", xseen); end
   endtask

   initial begin
      test_reset();
      test_ones();
      test_alternating();
      test_restart_ignored();
      test_mid_reset();
      test_skipped_boundary();
      test_back_to_back();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end
endmodule
